filter_ctrl: RTL and testbench

//  Sequences the moving-average filter. Debounces the requested window select and drives filt_sel.
//  On every accepted change or flush request, clears the delay chain with sclr.

---
 rtl/filter_pkg.sv | 32 +++
 rtl/sel_debounce.sv | 46 ++++
 rtl/filter_ctrl.sv | 117 +++++++++++
 tb/tb_filter_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the moving-average filter and its controller.
// Keeping the refill table here keeps the filter and controller in step.
package filter_pkg;

  localparam int unsigned SEL_W      = 3;
  localparam int unsigned FILL_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2
  } ctrl_state_e;

  localparam logic [SEL_W-1:0] SEL_WIN2  = 3'b000;
  localparam logic [SEL_W-1:0] SEL_WIN4  = 3'b001;
  localparam logic [SEL_W-1:0] SEL_WIN8  = 3'b010;
  localparam logic [SEL_W-1:0] SEL_WIN16 = 3'b011;

  // Cycles from the first non-clearing edge until the filter output has settled.
  function automatic logic [FILL_CNT_W-1:0] fill_len(input logic [SEL_W-1:0] sel);
    logic [FILL_CNT_W-1:0] len;
    case (sel)
      SEL_WIN2:  len = 5'd3;
      SEL_WIN4:  len = 5'd4;
      SEL_WIN8:  len = 5'd6;
      SEL_WIN16: len = 5'd10;
      default:   len = 5'd18;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Window-select debouncer: a new select is accepted only after it has been
// held steady long enough and differs from the select currently in use.
module sel_debounce
  import filter_pkg::*;
#(
  parameter int unsigned SEL_STABLE = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [SEL_W-1:0] sel_req,
  input  logic [SEL_W-1:0] cur_sel,
  output logic [SEL_W-1:0] cand,
  output logic             accept_c
);

  localparam int unsigned CNT_W = (SEL_STABLE > 1) ? $clog2(SEL_STABLE) : 1;
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(SEL_STABLE - 1);

  logic [SEL_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;

  always_comb begin
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    if (sel_req != cand_q) begin
      cand_d     = sel_req;
      stab_cnt_d = '0;
    end else if (stab_cnt_q < STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cand_q     <= '0;
      stab_cnt_q <= '0;
    end else begin
      cand_q     <= cand_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign cand     = cand_q;
  assign accept_c = (sel_req == cand_q) && (stab_cnt_q == STAB_MAX) && (cand_q != cur_sel);

endmodule

// File: rtl/filter_ctrl.sv
// Moving-average filter sequencer: debounced window select, flush with sclr,
// then blank the output until the selected window has refilled.
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned SEL_STABLE = 4,
  parameter int unsigned FLUSH_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic [2:0]           sel_req,
  input  logic                 flush_req,
  input  logic [BIT_WIDTH-1:0] filt_q,
  output logic [2:0]           filt_sel,
  output logic                 filt_sclr,
  output logic [BIT_WIDTH-1:0] q_out,
  output logic                 q_valid,
  output logic                 busy
);

  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYC + 1);

  ctrl_state_e            state_q, state_d;
  logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [FILL_CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [SEL_W-1:0]       filt_sel_q, filt_sel_d;
  logic                   filt_sclr_q, filt_sclr_d;
  logic [BIT_WIDTH-1:0]   q_out_q, q_out_d;
  logic                   q_valid_q, q_valid_d;
  logic                   busy_q, busy_d;
  logic [SEL_W-1:0]       cand;
  logic                   accept_c;
  logic                   restart_c;

  sel_debounce #(
    .SEL_STABLE (SEL_STABLE)
  ) u_sel_debounce (
    .clk      (clk),
    .aclr     (aclr),
    .sel_req  (sel_req),
    .cur_sel  (filt_sel_q),
    .cand     (cand),
    .accept_c (accept_c)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    filt_sel_d  = filt_sel_q;
    restart_c   = accept_c | flush_req;

    case (state_q)
      ST_RUN: state_d = ST_RUN;
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_W'(1)) begin
          state_d    = ST_FILL;
          fill_cnt_d = fill_len(filt_sel_q);
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        end
      end
      ST_FILL: begin
        if (fill_cnt_q == FILL_CNT_W'(1)) begin
          state_d = ST_RUN;
        end else begin
          fill_cnt_d = fill_cnt_q - FILL_CNT_W'(1);
        end
      end
      default: state_d = ST_FLUSH;
    endcase

    // A new select or flush request always (re)starts a full flush; select wins.
    if (restart_c) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = FLUSH_W'(FLUSH_CYC);
      if (accept_c) begin
        filt_sel_d = cand;
      end
    end

    filt_sclr_d = (state_d == ST_FLUSH);
    busy_d      = (state_d != ST_RUN);
    q_valid_d   = (state_q == ST_RUN);
    q_out_d     = (state_q == ST_RUN) ? filt_q : '0;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= FLUSH_W'(FLUSH_CYC);
      fill_cnt_q  <= '0;
      filt_sel_q  <= '0;
      filt_sclr_q <= 1'b1;
      q_out_q     <= '0;
      q_valid_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      filt_sel_q  <= filt_sel_d;
      filt_sclr_q <= filt_sclr_d;
      q_out_q     <= q_out_d;
      q_valid_q   <= q_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign filt_sel  = filt_sel_q;
  assign filt_sclr = filt_sclr_q;
  assign q_out     = q_out_q;
  assign q_valid   = q_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// Bench for filter_ctrl: filt_q is driven directly and every cycle the outputs
// are compared with a timeline model (flush start edge, run edge, select history).
module tb_filter_ctrl;

  localparam int unsigned BW         = 16;
  localparam int unsigned SEL_STABLE = 4;
  localparam int unsigned FLUSH_CYC  = 1;

  logic          clk = 1'b0;
  logic          aclr;
  logic [2:0]    sel_req = 3'b000;
  logic          flush_req = 1'b0;
  logic [BW-1:0] filt_q = '0;
  logic [2:0]    filt_sel;
  logic          filt_sclr;
  logic [BW-1:0] q_out;
  logic          q_valid;
  logic          busy;

  int vectors = 0;
  int errors  = 0;

  filter_ctrl #(
    .BIT_WIDTH  (BW),
    .SEL_STABLE (SEL_STABLE),
    .FLUSH_CYC  (FLUSH_CYC)
  ) dut (
    .clk       (clk),
    .aclr      (aclr),
    .sel_req   (sel_req),
    .flush_req (flush_req),
    .filt_q    (filt_q),
    .filt_sel  (filt_sel),
    .filt_sclr (filt_sclr),
    .q_out     (q_out),
    .q_valid   (q_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: edge index n since reset; a flush starting at edge t
  // keeps sclr for FLUSH_CYC edges and the design runs from edge t+FLUSH_CYC+len.
  int          n, t_flush, r_run, prev_run;
  logic [2:0]  m_sel, prev_val;
  logic        acc;
  logic [2:0]  e_sel;
  logic        e_sclr, e_valid, e_busy;
  logic [BW-1:0] e_q;

  function automatic int win_fill(input logic [2:0] s);
    if (s[2]) return 18;
    case (s[1:0])
      2'd0:    return 3;
      2'd1:    return 4;
      2'd2:    return 6;
      default: return 10;
    endcase
  endfunction

  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      n = 0; t_flush = 0; m_sel = 3'b000;
      r_run = FLUSH_CYC + win_fill(3'b000);
      prev_val = 3'b000; prev_run = 1;
      e_sel = 3'b000; e_sclr = 1'b1; e_valid = 1'b0; e_busy = 1'b1; e_q = '0;
    end else begin
      n = n + 1;
      e_valid = (n - 1 >= r_run);
      e_q     = e_valid ? filt_q : '0;
      acc = (sel_req == prev_val) && (prev_run >= SEL_STABLE) && (sel_req != m_sel);
      if (sel_req == prev_val) prev_run = prev_run + 1;
      else begin prev_val = sel_req; prev_run = 1; end
      if (acc) m_sel = sel_req;
      if (acc || flush_req) begin
        t_flush = n;
        r_run   = n + FLUSH_CYC + win_fill(m_sel);
      end
      e_sel  = m_sel;
      e_sclr = (n < t_flush + FLUSH_CYC);
      e_busy = (n < r_run);
    end
  end

  logic [21:0] dut_v, exp_v, rst_v;
  assign dut_v = {filt_sel, filt_sclr, q_valid, busy, q_out};
  assign exp_v = {e_sel, e_sclr, e_valid, e_busy, e_q};
  assign rst_v = {3'b000, 1'b1, 1'b0, 1'b1, 16'h0000};

  task automatic test_reset();
    aclr = 1'b0;
    #3 aclr = 1'b1;
    #1;
    vectors++;
    if (dut_v !== rst_v) begin
      errors++; $display("FAIL reset_async: got %h want %h", dut_v, rst_v);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_v !== rst_v) begin
      errors++; $display("FAIL reset_held: got %h want %h", dut_v, rst_v);
    end
    @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic test_startup();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); filt_q = 16'd1000;
      @(posedge clk); #1;
      vectors++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL startup cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_sel_change();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); sel_req = 3'b011; filt_q = 16'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL sel_change cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    int lows = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sel_req = (i < 2) ? 3'b100 : 3'b011;
      filt_q  = 16'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL glitch cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
      if (!q_valid) lows++;
    end
    vectors++;
    if (lows !== 0) begin
      errors++; $display("FAIL glitch_valid_drop: got %0d low cycles want 0", lows);
    end
  endtask

  task automatic test_flush_mid_fill();
    int rises = 0;
    logic last_v = q_valid;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      sel_req   = 3'b101;
      flush_req = (i == 16);
      filt_q    = 16'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL flush_mid_fill cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
      if (q_valid && !last_v) rises++;
      last_v = q_valid;
    end
    flush_req = 1'b0;
    vectors++;
    if (rises !== 1) begin
      errors++; $display("FAIL flush_mid_fill_rises: got %0d want 1", rises);
    end
  endtask

  task automatic test_sign();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      sel_req = 3'b010;
      filt_q  = (i % 2 == 0) ? 16'(2000) : 16'(-2000);
      @(posedge clk); #1;
      vectors++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL sign cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int phase = 0; phase < 2; phase++) begin
      // phase 0 cuts into FILL right after a flush; phase 1 cuts into RUN
      for (int i = 0; i < ((phase == 0) ? 4 : 12); i++) begin
        @(negedge clk);
        sel_req   = 3'b000;
        flush_req = (phase == 0 && i == 0);
        filt_q    = 16'($urandom);
        @(posedge clk); #1;
        vectors++;
        if (dut_v !== exp_v) begin
          errors++; $display("FAIL async_pre%0d cyc %0d: got %h want %h", phase, i, dut_v, exp_v);
        end
      end
      flush_req = 1'b0;
      @(negedge clk); #2 aclr = 1'b1;
      #1;
      vectors++;
      if (dut_v !== rst_v) begin
        errors++; $display("FAIL async_assert%0d: got %h want %h", phase, dut_v, rst_v);
      end
      @(posedge clk); #1;
      vectors++;
      if (dut_v !== rst_v) begin
        errors++; $display("FAIL async_hold%0d: got %h want %h", phase, dut_v, rst_v);
      end
      @(negedge clk); aclr = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); filt_q = 16'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL async_post cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) sel_req = 3'($urandom);
      flush_req = ($urandom_range(0, 29) == 0);
      filt_q    = 16'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", i, dut_v, exp_v);
      end
    end
    flush_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_sel_change();
    test_glitch();
    test_flush_mid_fill();
    test_sign();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
